// File: rtl/ps2_ascii_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_ascii_decoder_if
//  Description : Bundles the scan-code input handshake and the character FIFO
//                read side of ps2_ascii_decoder. The master drives scan codes,
//                pops and overflow clear; the slave (decoder) returns the rest.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_ascii_decoder_if;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_rdn;
    logic       rd;
    logic [6:0] ascii;
    logic       valid;
    logic       overflow;
    logic       clr_ovf;
    logic       shift_st;
    logic       caps_st;

    modport master (
        output ps2_data, ps2_ready, rd, clr_ovf,
        input  ps2_rdn, ascii, valid, overflow, shift_st, caps_st
    );

    modport slave (
        input  ps2_data, ps2_ready, rd, clr_ovf,
        output ps2_rdn, ascii, valid, overflow, shift_st, caps_st
    );
endinterface
`default_nettype wire

// File: rtl/ps2_ascii_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_ascii_decoder
//  Description : Pops PS/2 set-2 scan codes, tracks break/extended prefixes,
//                Shift and Caps Lock, translates printable make codes to 7-bit
//                ASCII and buffers the characters in a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii_decoder #(
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               clrn,
    ps2_ascii_decoder_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACK    = 2'd1,
        S_DECODE = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [7:0]           code_q,    code_d;
    logic                 ps2_rdn_q, ps2_rdn_d;
    logic                 brk_q,     brk_d;
    logic                 ext_q,     ext_d;
    logic                 shift_q,   shift_d;
    logic                 caps_q,    caps_d;
    logic                 ovf_q,     ovf_d;
    logic [FIFO_AW-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [FIFO_AW:0]     count_q,   count_d;
    logic [6:0]           mem_q [DEPTH];
    logic [6:0]           mem_d [DEPTH];

    logic                 push;
    logic [6:0]           push_char;
    logic [7:0]           look;
    logic                 do_pop;
    logic                 do_write;
    logic                 full;

    // Selects between the unshifted and shifted character of a key; bit 7 = hit.
    function automatic logic [7:0] pick(input logic sel, input logic [6:0] lo, input logic [6:0] hi);
        return {1'b1, (sel ? hi : lo)};
    endfunction

    // Scan code to ASCII. 'sh' = Shift held, 'up' = letters uppercase.
    function automatic logic [7:0] lookup(input logic [7:0] c, input logic sh, input logic up);
        logic [7:0] r;
        r = 8'h00;
        case (c)
            8'h1C: r = pick(up, 7'h61, 7'h41);  8'h32: r = pick(up, 7'h62, 7'h42);
            8'h21: r = pick(up, 7'h63, 7'h43);  8'h23: r = pick(up, 7'h64, 7'h44);
            8'h24: r = pick(up, 7'h65, 7'h45);  8'h2B: r = pick(up, 7'h66, 7'h46);
            8'h34: r = pick(up, 7'h67, 7'h47);  8'h33: r = pick(up, 7'h68, 7'h48);
            8'h43: r = pick(up, 7'h69, 7'h49);  8'h3B: r = pick(up, 7'h6A, 7'h4A);
            8'h42: r = pick(up, 7'h6B, 7'h4B);  8'h4B: r = pick(up, 7'h6C, 7'h4C);
            8'h3A: r = pick(up, 7'h6D, 7'h4D);  8'h31: r = pick(up, 7'h6E, 7'h4E);
            8'h44: r = pick(up, 7'h6F, 7'h4F);  8'h4D: r = pick(up, 7'h70, 7'h50);
            8'h15: r = pick(up, 7'h71, 7'h51);  8'h2D: r = pick(up, 7'h72, 7'h52);
            8'h1B: r = pick(up, 7'h73, 7'h53);  8'h2C: r = pick(up, 7'h74, 7'h54);
            8'h3C: r = pick(up, 7'h75, 7'h55);  8'h2A: r = pick(up, 7'h76, 7'h56);
            8'h1D: r = pick(up, 7'h77, 7'h57);  8'h22: r = pick(up, 7'h78, 7'h58);
            8'h35: r = pick(up, 7'h79, 7'h59);  8'h1A: r = pick(up, 7'h7A, 7'h5A);
            // digit row: 0..9 / ) ! @ # $ % ^ & * (
            8'h45: r = pick(sh, 7'h30, 7'h29);  8'h16: r = pick(sh, 7'h31, 7'h21);
            8'h1E: r = pick(sh, 7'h32, 7'h40);  8'h26: r = pick(sh, 7'h33, 7'h23);
            8'h25: r = pick(sh, 7'h34, 7'h24);  8'h2E: r = pick(sh, 7'h35, 7'h25);
            8'h36: r = pick(sh, 7'h36, 7'h5E);  8'h3D: r = pick(sh, 7'h37, 7'h26);
            8'h3E: r = pick(sh, 7'h38, 7'h2A);  8'h46: r = pick(sh, 7'h39, 7'h28);
            // punctuation: , . - = ; ' /  and their US shifted pairs
            8'h41: r = pick(sh, 7'h2C, 7'h3C);  8'h49: r = pick(sh, 7'h2E, 7'h3E);
            8'h4E: r = pick(sh, 7'h2D, 7'h5F);  8'h55: r = pick(sh, 7'h3D, 7'h2B);
            8'h4C: r = pick(sh, 7'h3B, 7'h3A);  8'h52: r = pick(sh, 7'h27, 7'h22);
            8'h4A: r = pick(sh, 7'h2F, 7'h3F);
            // control keys are not affected by Shift
            8'h29: r = 8'h80 | 8'h20;           8'h5A: r = 8'h80 | 8'h0D;
            8'h66: r = 8'h80 | 8'h08;           8'h0D: r = 8'h80 | 8'h09;
            8'h76: r = 8'h80 | 8'h1B;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Next-state logic for the scan FSM, modifier tracking and character FIFO.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        ps2_rdn_d = ps2_rdn_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        shift_d   = shift_q;
        caps_d    = caps_q;
        push      = 1'b0;
        push_char = 7'h00;
        look      = lookup(code_q, shift_q, shift_q ^ caps_q);

        case (state_q)
            S_IDLE: begin
                if (bus.ps2_ready) begin
                    code_d    = bus.ps2_data;
                    ps2_rdn_d = 1'b0;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                ps2_rdn_d = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_WAIT;
                if (code_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (code_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else begin
                    // Prefixes only apply to the byte that immediately follows them.
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                    if (!ext_q && (code_q == 8'h12 || code_q == 8'h59)) begin
                        shift_d = ~brk_q;
                    end
                    if (!ext_q && !brk_q && code_q == 8'h58) begin
                        caps_d = ~caps_q;
                    end
                    if (!brk_q) begin
                        if (ext_q) begin
                            // Keypad Enter is the only extended key that yields a character.
                            push      = (code_q == 8'h5A);
                            push_char = 7'h0D;
                        end else begin
                            push      = look[7];
                            push_char = look[6:0];
                        end
                    end
                end
            end
            S_WAIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        full     = (count_q == (FIFO_AW+1)'(DEPTH));
        do_pop   = bus.rd && (count_q != '0);
        // A pop in the same cycle frees the slot the push lands in, even when full.
        do_write = push && (!full || do_pop);

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_write) begin
            mem_d[wr_ptr_q] = push_char;
        end

        wr_ptr_d = do_write ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop   ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;

        case ({do_write, do_pop})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase

        // A drop wins over a simultaneous clear so no lost character goes unreported.
        if (push && !do_write) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            code_q    <= 8'h00;
            ps2_rdn_q <= 1'b1;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            shift_q   <= 1'b0;
            caps_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 7'h00;
            end
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            ps2_rdn_q <= ps2_rdn_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            shift_q   <= shift_d;
            caps_q    <= caps_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.ps2_rdn  = ps2_rdn_q;
    assign bus.ascii    = mem_q[rd_ptr_q];
    assign bus.valid    = (count_q != '0);
    assign bus.overflow = ovf_q;
    assign bus.shift_st = shift_q;
    assign bus.caps_st  = caps_q;
endmodule
`default_nettype wire

// File: tb/tb_ps2_ascii_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_ascii_decoder
//  Description : Scoreboard bench for ps2_ascii_decoder. Scan codes go through
//                a keyboard-FIFO stand-in; a reference model pushes expected
//                characters that a separate monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_ascii_decoder;
    logic clk  = 1'b0;
    logic clrn = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    bit   reader_en = 1'b1;
    bit   force_rd  = 1'b0;

    logic [7:0] src_q [$];
    logic [6:0] exp_q [$];

    // reference model state
    bit m_brk, m_ext, m_shift, m_caps;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] punct_codes [7]  = '{8'h41, 8'h49, 8'h4E, 8'h55, 8'h4C, 8'h52, 8'h4A};
    logic [7:0] spec_codes  [5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [6:0] spec_chars  [5]  = '{7'h20, 7'h0D, 7'h08, 7'h09, 7'h1B};
    string digit_shift = ")!@#$%^&*(";
    string punct_lo    = ",.-=;'/";
    string punct_hi    = "<>_+:\"?";

    ps2_ascii_decoder_if bus ();

    ps2_ascii_decoder #(.FIFO_AW(3)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    // Character a key produces under the current modifier state, if any.
    task automatic ref_lookup(input logic [7:0] c, output bit hit, output logic [6:0] ch);
        hit = 1'b0;
        ch  = 7'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c) begin
                hit = 1'b1;
                ch  = (m_shift ^ m_caps) ? 7'(65 + i) : 7'(97 + i);
            end
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c) begin
                hit = 1'b1;
                ch  = m_shift ? 7'(digit_shift[i]) : 7'(48 + i);
            end
        for (int i = 0; i < 7; i++)
            if (punct_codes[i] == c) begin
                hit = 1'b1;
                ch  = m_shift ? 7'(punct_hi[i]) : 7'(punct_lo[i]);
            end
        for (int i = 0; i < 5; i++)
            if (spec_codes[i] == c) begin
                hit = 1'b1;
                ch  = spec_chars[i];
            end
    endtask

    // Applies one scan byte to the model; optionally queues the expected character.
    task automatic model_byte(input logic [7:0] c, input bit use_out);
        bit         hit;
        logic [6:0] ch;
        hit = 1'b0;
        ch  = 7'h00;
        if (c == 8'hF0) m_brk = 1'b1;
        else if (c == 8'hE0) m_ext = 1'b1;
        else begin
            if (!m_brk) begin
                if (m_ext) begin
                    hit = (c == 8'h5A);
                    ch  = 7'h0D;
                end else ref_lookup(c, hit, ch);
            end
            if (!m_ext && (c == 8'h12 || c == 8'h59)) m_shift = !m_brk;
            if (!m_ext && !m_brk && c == 8'h58) m_caps = !m_caps;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        if (hit && use_out) exp_q.push_back(ch);
    endtask

    task automatic feed(input logic [7:0] c, input bit use_out);
        model_byte(c, use_out);
        src_q.push_back(c);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (src_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (src_q.size() != 0) timeout_fail("src_drain");
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.valid) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_exp_empty"}, exp_q.size(), 0);
        check({name, "_valid0"}, bus.valid, 1'b0);
    endtask

    task automatic wait_rdn_low();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 50) begin
            @(posedge clk);
            #1;
            seen = !bus.ps2_rdn;
            n++;
        end
        if (!seen) timeout_fail("rdn_low");
    endtask

    // Keyboard-FIFO stand-in: pops on the low strobe, presents the next head.
    always @(negedge clk) begin
        if (clrn && !bus.ps2_rdn && src_q.size() > 0) void'(src_q.pop_front());
        bus.ps2_ready = (src_q.size() != 0);
        bus.ps2_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    end

    // Monitor: compares each presented character with the scoreboard head and pops it.
    always @(negedge clk) begin
        bus.rd = 1'b0;
        if (clrn && bus.valid && (reader_en || force_rd)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_char: got %0h required none", bus.ascii);
            end else begin
                check("char", bus.ascii, exp_q.pop_front());
            end
            bus.rd = 1'b1;
            pops++;
        end
    end

    initial begin
        logic [7:0] pool [$];
        logic [7:0] c;
        bit         prev_e0;
        int         pops0;

        bus.clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdn", bus.ps2_rdn, 1'b1);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_ascii", bus.ascii, 7'h00);
        check("rst_ovf", bus.overflow, 1'b0);
        check("rst_shift", bus.shift_st, 1'b0);
        check("rst_caps", bus.caps_st, 1'b0);
        clrn = 1'b1;

        // 1: single make code, strobe width and latency
        feed(8'h1C, 1'b0);
        exp_q.push_back(7'h61);
        wait_rdn_low();
        @(posedge clk); #1;
        check("t1_rdn_one_cycle", bus.ps2_rdn, 1'b1);
        check("t1_valid_n1", bus.valid, 1'b0);
        @(posedge clk); #1;
        check("t1_valid_n2", bus.valid, 1'b1);
        wait_idle();
        drain("t1");

        // 2: shift make/break
        foreach (letter_codes[i]) if (i == 0) begin end
        feed(8'h12, 1'b0); feed(8'h1C, 1'b0); feed(8'hF0, 1'b0); feed(8'h1C, 1'b0);
        feed(8'hF0, 1'b0); feed(8'h12, 1'b0); feed(8'h1C, 1'b0);
        exp_q.push_back(7'h41);
        exp_q.push_back(7'h61);
        wait_idle();
        drain("t2");
        check("t2_shift", bus.shift_st, 1'b0);

        // 3: caps lock toggle, combined with shift
        feed(8'h58, 1'b0); feed(8'hF0, 1'b0); feed(8'h58, 1'b0); feed(8'h32, 1'b0);
        feed(8'h12, 1'b0); feed(8'h32, 1'b0);
        exp_q.push_back(7'h42);
        exp_q.push_back(7'h62);
        wait_idle();
        drain("t3");
        check("t3_caps", bus.caps_st, 1'b1);
        check("t3_shift", bus.shift_st, 1'b1);
        feed(8'hF0, 1'b0); feed(8'h12, 1'b0); feed(8'h58, 1'b0);
        wait_idle();
        check("t3_caps_off", bus.caps_st, 1'b0);
        check("t3_shift_off", bus.shift_st, 1'b0);

        // 4: extended keys
        feed(8'hE0, 1'b0); feed(8'h5A, 1'b0); feed(8'hE0, 1'b0); feed(8'h75, 1'b0);
        feed(8'h66, 1'b0);
        exp_q.push_back(7'h0D);
        exp_q.push_back(7'h08);
        wait_idle();
        drain("t4");

        // 5: overflow, then simultaneous pop and push while full
        reader_en = 1'b0;
        for (int i = 0; i < 9; i++) feed(letter_codes[i], 1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(7'(97 + i));
        wait_idle();
        check("t5_valid_full", bus.valid, 1'b1);
        check("t5_ovf", bus.overflow, 1'b1);
        check("t5_head", bus.ascii, 7'h61);
        @(posedge clk); #1; bus.clr_ovf = 1'b1;
        @(posedge clk); #1; bus.clr_ovf = 1'b0;
        check("t5_ovf_clr", bus.overflow, 1'b0);
        feed(letter_codes[9], 1'b0);
        exp_q.push_back(7'h6A);
        wait_rdn_low();
        @(posedge clk); #1; force_rd = 1'b1;
        @(posedge clk); #1; force_rd = 1'b0;
        check("t5_ovf_no_drop", bus.overflow, 1'b0);
        check("t5_new_head", bus.ascii, 7'h62);
        wait_idle();
        pops0 = pops;
        reader_en = 1'b1;
        drain("t5");
        check("t5_count_kept", pops - pops0, 8);

        // random traffic against the reference model
        foreach (letter_codes[i]) pool.push_back(letter_codes[i]);
        foreach (digit_codes[i])  pool.push_back(digit_codes[i]);
        foreach (punct_codes[i])  pool.push_back(punct_codes[i]);
        foreach (spec_codes[i])   pool.push_back(spec_codes[i]);
        pool.push_back(8'h12); pool.push_back(8'h59); pool.push_back(8'h58);
        pool.push_back(8'h12); pool.push_back(8'h75); pool.push_back(8'h0E); pool.push_back(8'h05);
        prev_e0 = 1'b0;
        for (int blk = 0; blk < 10; blk++) begin
            for (int k = 0; k < 8; k++) begin
                int r = $urandom_range(0, 99);
                if (r < 15) c = 8'hF0;
                else if (r < 20 && !prev_e0) c = 8'hE0;
                else c = pool[$urandom_range(0, pool.size() - 1)];
                if (prev_e0 && c == 8'h58) c = 8'h5A;
                prev_e0 = (c == 8'hE0);
                feed(c, 1'b1);
            end
            wait_idle();
            check("rnd_shift", bus.shift_st, m_shift);
            check("rnd_caps", bus.caps_st, m_caps);
        end
        feed(8'h1C, 1'b1);
        wait_idle();
        drain("rnd");

        // 6: reset while the byte is being acknowledged
        feed(8'h12, 1'b0); feed(8'h58, 1'b0);
        wait_idle();
        check("t6_shift_pre", bus.shift_st, 1'b1);
        check("t6_caps_pre", bus.caps_st, 1'b1);
        src_q.push_back(8'h1C);
        wait_rdn_low();
        clrn = 1'b0;
        #1;
        check("t6_rdn", bus.ps2_rdn, 1'b1);
        check("t6_valid", bus.valid, 1'b0);
        check("t6_ascii", bus.ascii, 7'h00);
        check("t6_ovf", bus.overflow, 1'b0);
        check("t6_shift", bus.shift_st, 1'b0);
        check("t6_caps", bus.caps_st, 1'b0);
        m_brk = 1'b0; m_ext = 1'b0; m_shift = 1'b0; m_caps = 1'b0;
        exp_q.push_back(7'h61);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        wait_idle();
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
